// File: rtl/mem_bist_ctrl_if.sv
// Purpose : bundles the BIST controller's request/result and memory-side
//           signals into one interface.
// Ports   : start/seed in; busy/done/pass/err_count/fail_addr out;
//           mem_addr/mem_wdata/mem_wr out, mem_rdata in.
// Modports: master = controller side, slave = requester + memory side.
interface mem_bist_ctrl_if #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 4,
  parameter int ERR_WIDTH  = 8
);
  logic                  start;
  logic [DATA_WIDTH-1:0] seed;
  logic                  busy;
  logic                  done;
  logic                  pass;
  logic [ERR_WIDTH-1:0]  err_count;
  logic [ADDR_WIDTH-1:0] fail_addr;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_wr;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    input  start, seed, mem_rdata,
    output busy, done, pass, err_count, fail_addr, mem_addr, mem_wdata, mem_wr
  );

  modport slave (
    output start, seed, mem_rdata,
    input  busy, done, pass, err_count, fail_addr, mem_addr, mem_wdata, mem_wr
  );
endinterface

// File: rtl/mem_bist_ctrl.sv
// Purpose : march-style self-test of a single-port memory: write P, read P,
//           write ~P, read ~P over addresses 0..DEPTH-1, P(a) = seed ^ a.
// Latency : start accepted at edge 0 -> done pulse in cycle 4*DEPTH+1.
// Backpressure: none; start outside IDLE is dropped, not queued.
// Ports   : i_clk, i_rst (sync, active-high), bus (mem_bist_ctrl_if.master).
// Option  : MEM_BIST_STOP_ON_FAIL_EN - first read mismatch jumps to DONE.
// All outputs are driven straight from flops.
module mem_bist_ctrl #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 4,
  parameter int DEPTH      = 8,
  parameter int ERR_WIDTH  = 8
) (
  input  logic            i_clk,
  input  logic            i_rst,
  mem_bist_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR0,
    S_RD0,
    S_WR1,
    S_RD1,
    S_DONE
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ERR_WIDTH-1:0]  ERR_MAX   = '1;

  // Address is zero-extended or truncated to the word width before the XOR.
  function automatic logic [DATA_WIDTH-1:0] pattern(
    input logic [DATA_WIDTH-1:0] s,
    input logic [ADDR_WIDTH-1:0] a,
    input logic                  inv
  );
    pattern = (s ^ DATA_WIDTH'(a)) ^ {DATA_WIDTH{inv}};
  endfunction

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_seed;
  logic [ERR_WIDTH-1:0]  r_err;
  logic [ADDR_WIDTH-1:0] r_fail;
  logic                  r_pass;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_mem_wr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;

  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] w_addr_nxt;
  logic [DATA_WIDTH-1:0] w_seed_nxt;
  logic [ERR_WIDTH-1:0]  w_err_nxt;
  logic [ADDR_WIDTH-1:0] w_fail_nxt;
  logic                  w_pass_nxt;
  logic                  w_wr_nxt;
  logic [DATA_WIDTH-1:0] w_wdata_nxt;
  logic [DATA_WIDTH-1:0] w_expect;
  logic                  w_is_rd;
  logic                  w_mismatch;
  logic                  w_last;

  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_seed_nxt  = r_seed;
    w_err_nxt   = r_err;
    w_fail_nxt  = r_fail;
    w_pass_nxt  = r_pass;
    w_wr_nxt    = 1'b0;
    w_wdata_nxt = '0;

    // mem_addr is the r_addr flop and the memory reads combinationally, so
    // mem_rdata belongs to r_addr during this cycle.
    w_is_rd    = (r_state == S_RD0) || (r_state == S_RD1);
    w_expect   = pattern(r_seed, r_addr, r_state == S_RD1);
    w_mismatch = w_is_rd && (bus.mem_rdata != w_expect);
    w_last     = (r_addr == LAST_ADDR);

    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_nxt = S_WR0;
          w_addr_nxt  = '0;
          w_seed_nxt  = bus.seed;
          w_err_nxt   = '0;
          w_fail_nxt  = '0;
          w_pass_nxt  = 1'b0;
        end
      end
      S_WR0, S_RD0, S_WR1, S_RD1: begin
        if (w_last) begin
          w_addr_nxt = '0;
          case (r_state)
            S_WR0:   w_state_nxt = S_RD0;
            S_RD0:   w_state_nxt = S_WR1;
            S_WR1:   w_state_nxt = S_RD1;
            default: w_state_nxt = S_DONE;
          endcase
        end else begin
          w_addr_nxt = r_addr + ADDR_WIDTH'(1);
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_addr_nxt  = '0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_addr_nxt  = '0;
      end
    endcase

    if (w_mismatch) begin
      if (r_err != ERR_MAX) begin
        w_err_nxt = r_err + ERR_WIDTH'(1);
      end
      if (r_err == '0) begin
        w_fail_nxt = r_addr;
      end
`ifdef MEM_BIST_STOP_ON_FAIL_EN
      // Abandon the remaining sweeps; only the first mismatch is recorded.
      w_state_nxt = S_DONE;
      w_addr_nxt  = '0;
`endif
    end

    // The last compare lands on the same edge that enters DONE, so the
    // verdict is taken from the updated count.
    if (w_state_nxt == S_DONE) begin
      w_pass_nxt = (w_err_nxt == '0);
    end

    // Write strobe and data are registered one cycle ahead of use, so they
    // are built from the next state/address/seed.
    if ((w_state_nxt == S_WR0) || (w_state_nxt == S_WR1)) begin
      w_wr_nxt    = 1'b1;
      w_wdata_nxt = pattern(w_seed_nxt, w_addr_nxt, w_state_nxt == S_WR1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_seed      <= '0;
      r_err       <= '0;
      r_fail      <= '0;
      r_pass      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_mem_wdata <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_addr      <= w_addr_nxt;
      r_seed      <= w_seed_nxt;
      r_err       <= w_err_nxt;
      r_fail      <= w_fail_nxt;
      r_pass      <= w_pass_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
      r_done      <= (w_state_nxt == S_DONE);
      r_mem_wr    <= w_wr_nxt;
      r_mem_wdata <= w_wdata_nxt;
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.pass      = r_pass;
  assign bus.err_count = r_err;
  assign bus.fail_addr = r_fail;
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_wr    = r_mem_wr;

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Bench for mem_bist_ctrl: a default instance (DEPTH 8, ERR_WIDTH 8) and a
// DEPTH 6 / ERR_WIDTH 3 instance, each with its own memory model that can
// inject a stuck bit or return all-zero data.
module tb_mem_bist_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_bist_ctrl_if #(.ADDR_WIDTH(3), .DATA_WIDTH(4), .ERR_WIDTH(8)) ifa ();
  mem_bist_ctrl_if #(.ADDR_WIDTH(3), .DATA_WIDTH(4), .ERR_WIDTH(3)) ifb ();

  mem_bist_ctrl #(.ADDR_WIDTH(3), .DATA_WIDTH(4), .DEPTH(8), .ERR_WIDTH(8)) dut_a (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (ifa)
  );

  mem_bist_ctrl #(.ADDR_WIDTH(3), .DATA_WIDTH(4), .DEPTH(6), .ERR_WIDTH(3)) dut_b (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (ifb)
  );

  // Memory fault configuration shared by both memory models.
  bit         zero_mode;
  bit         f_en;
  logic [2:0] f_addr;
  int         f_bit;
  bit         f_val;

  logic [3:0] mem_a [8];
  logic [3:0] mem_b [8];

  function automatic logic [3:0] rd_fault(input logic [2:0] a, input logic [3:0] d,
                                          input bit zm, input bit fe, input logic [2:0] fa,
                                          input int fb, input bit fv);
    logic [3:0] r;
    r = d;
    if (zm) r = 4'h0;
    else if (fe && (a == fa)) r[fb] = fv;
    return r;
  endfunction

  assign ifa.mem_rdata = rd_fault(ifa.mem_addr, mem_a[ifa.mem_addr], zero_mode, f_en, f_addr, f_bit, f_val);
  assign ifb.mem_rdata = rd_fault(ifb.mem_addr, mem_b[ifb.mem_addr], zero_mode, f_en, f_addr, f_bit, f_val);

  always @(posedge clk) begin
    if (ifa.mem_wr) mem_a[ifa.mem_addr] <= ifa.mem_wdata;
    if (ifb.mem_wr) mem_b[ifb.mem_addr] <= ifb.mem_wdata;
  end

  // Observation of whichever instance is under test.
  bit sel;
  wire       m_busy  = sel ? ifb.busy   : ifa.busy;
  wire       m_done  = sel ? ifb.done   : ifa.done;
  wire       m_pass  = sel ? ifb.pass   : ifa.pass;
  wire       m_wr    = sel ? ifb.mem_wr : ifa.mem_wr;
  wire [7:0] m_err   = sel ? {5'b0, ifb.err_count} : ifa.err_count;
  wire [2:0] m_fail  = sel ? ifb.fail_addr : ifa.fail_addr;
  wire [2:0] m_addr  = sel ? ifb.mem_addr  : ifa.mem_addr;
  wire [3:0] m_wdata = sel ? ifb.mem_wdata : ifa.mem_wdata;

  int n_checks;
  int n_fail;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: both read sweeps see the stored pattern through the fault
  // model; mismatches are counted with saturation, first one is recorded.
  task automatic model(input logic [3:0] sd, input int depth, input int errmax,
                       output int err, output int fa);
    logic [3:0] expv;
    logic [3:0] got;
    err = 0;
    fa  = 0;
    for (int ph = 0; ph < 2; ph++) begin
      for (int a = 0; a < depth; a++) begin
        expv = sd ^ 4'(a) ^ ((ph == 1) ? 4'hF : 4'h0);
        got  = rd_fault(3'(a), expv, zero_mode, f_en, f_addr, f_bit, f_val);
        if (got !== expv) begin
          if (err == 0) fa = a;
          if (err < errmax) err++;
        end
      end
    end
  endtask

  task automatic drive_start(input bit s, input logic v, input logic [3:0] sd);
    if (s) begin
      ifb.start = v;
      ifb.seed  = sd;
    end else begin
      ifa.start = v;
      ifa.seed  = sd;
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_busy"},  32'(m_busy),  32'd0);
    chk({tag, "_done"},  32'(m_done),  32'd0);
    chk({tag, "_pass"},  32'(m_pass),  32'd0);
    chk({tag, "_wr"},    32'(m_wr),    32'd0);
    chk({tag, "_err"},   32'(m_err),   32'd0);
    chk({tag, "_fail"},  32'(m_fail),  32'd0);
    chk({tag, "_addr"},  32'(m_addr),  32'd0);
    chk({tag, "_wdata"}, 32'(m_wdata), 32'd0);
  endtask

  // Called one time unit after a rising edge; start is raised for the
  // current cycle ("cycle 0"), accepted at its closing edge.
  task automatic run(input string tag, input bit s, input logic [3:0] sd, input int depth,
                     input int errmax, input int restart_at, input int abort_at, input bit chain);
    int exp_err;
    int exp_fa;
    int ph;
    int a;
    bit exp_wr;
    logic [3:0] pat;
    model(sd, depth, errmax, exp_err, exp_fa);
    sel = s;
    drive_start(s, 1'b1, sd);
    @(posedge clk); #1;
    drive_start(s, 1'b0, ~sd);
    for (int n = 1; n <= 4 * depth + 1; n++) begin
      if (n == abort_at) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset({tag, "_abort"});
        for (int k = 0; k < 2 * depth + 4; k++) begin
          @(negedge clk);
          chk({tag, "_abort_nodone"}, 32'(m_done), 32'd0);
          chk({tag, "_abort_idle"},   32'(m_busy), 32'd0);
        end
        @(posedge clk); #1;
        return;
      end
      if (n == restart_at) drive_start(s, 1'b1, ~sd);
      @(negedge clk);
      if (n <= 4 * depth) begin
        ph     = (n - 1) / depth;
        a      = (n - 1) % depth;
        exp_wr = (ph == 0) || (ph == 2);
        pat    = sd ^ 4'(a) ^ ((ph == 2) ? 4'hF : 4'h0);
        chk({tag, "_addr"}, 32'(m_addr), 32'(a));
        chk({tag, "_wr"},   32'(m_wr),   32'(exp_wr));
        if (exp_wr) chk({tag, "_wdata"}, 32'(m_wdata), 32'(pat));
        chk({tag, "_busy"}, 32'(m_busy), 32'd1);
        chk({tag, "_done_early"}, 32'(m_done), 32'd0);
        if (n == 1) begin
          chk({tag, "_clr_pass"}, 32'(m_pass), 32'd0);
          chk({tag, "_clr_err"},  32'(m_err),  32'd0);
          chk({tag, "_clr_fail"}, 32'(m_fail), 32'd0);
        end
      end else begin
        chk({tag, "_done"},      32'(m_done), 32'd1);
        chk({tag, "_done_busy"}, 32'(m_busy), 32'd1);
        chk({tag, "_done_wr"},   32'(m_wr),   32'd0);
        chk({tag, "_pass"},      32'(m_pass), 32'(exp_err == 0));
        chk({tag, "_err"},       32'(m_err),  32'(exp_err));
        if (exp_err != 0) chk({tag, "_fail_addr"}, 32'(m_fail), 32'(exp_fa));
      end
      @(posedge clk); #1;
      if (n == restart_at) drive_start(s, 1'b0, sd);
    end
    if (!chain) begin
      @(negedge clk);
      chk({tag, "_post_busy"}, 32'(m_busy), 32'd0);
      chk({tag, "_post_done"}, 32'(m_done), 32'd0);
      chk({tag, "_hold_pass"}, 32'(m_pass), 32'(exp_err == 0));
      chk({tag, "_hold_err"},  32'(m_err),  32'(exp_err));
      if (exp_err != 0) chk({tag, "_hold_fail"}, 32'(m_fail), 32'(exp_fa));
      @(posedge clk); #1;
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    sel       = 1'b0;
    zero_mode = 1'b0;
    f_en      = 1'b0;
    f_addr    = 3'd0;
    f_bit     = 0;
    f_val     = 1'b0;
    for (int i = 0; i < 8; i++) begin
      mem_a[i] = 4'h0;
      mem_b[i] = 4'h0;
    end
    drive_start(1'b0, 1'b0, 4'h0);
    drive_start(1'b1, 1'b0, 4'h0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    sel = 1'b0;
    check_reset("reset_a");
    sel = 1'b1;
    check_reset("reset_b");
    @(posedge clk); #1;
    rst = 1'b0;

    // Ideal memory, seed A: writes A,B,8,9,E,F,C,D; done in cycle 33.
    run("ideal_a", 1'b0, 4'hA, 8, 255, 0, 0, 1'b0);

    // Bit 0 stuck at 0 at address 3; the next start comes in the cycle
    // right after done and must clear the result.
    f_en = 1'b1; f_addr = 3'd3; f_bit = 0; f_val = 1'b0;
    run("stuck3", 1'b0, 4'hA, 8, 255, 0, 0, 1'b1);

    // Chained start with a second start pulse during RD0 (ignored).
    f_en = 1'b0;
    run("restart", 1'b0, 4'h5, 8, 255, 12, 0, 1'b0);

    // Reset during WR1 after a mismatch has been counted, then rerun.
    f_en = 1'b1;
    run("abort", 1'b0, 4'hA, 8, 255, 0, 20, 1'b0);
    run("after_abort", 1'b0, 4'h3, 8, 255, 0, 0, 1'b0);

    // Randomised seeds and stuck-at faults.
    for (int k = 0; k < 8; k++) begin
      f_en   = 1'($urandom_range(0, 1));
      f_addr = 3'($urandom_range(0, 7));
      f_bit  = int'($urandom_range(0, 3));
      f_val  = 1'($urandom_range(0, 1));
      run("rand_a", 1'b0, 4'($urandom), 8, 255, 0, 0, 1'($urandom_range(0, 1)));
    end

    // DEPTH 6 instance: ideal memory, done in cycle 25, addresses 0..5 only.
    f_en = 1'b0;
    run("ideal_b", 1'b1, 4'h6, 6, 7, 0, 0, 1'b0);

    // All-zero read data, seed 0: counter saturates at 7, first fail at 1.
    zero_mode = 1'b1;
    run("zero_b", 1'b1, 4'h0, 6, 7, 0, 0, 1'b0);
    zero_mode = 1'b0;

    for (int k = 0; k < 4; k++) begin
      f_en   = 1'b1;
      f_addr = 3'($urandom_range(0, 7));
      f_bit  = int'($urandom_range(0, 3));
      f_val  = 1'($urandom_range(0, 1));
      run("rand_b", 1'b1, 4'($urandom), 6, 7, 0, 0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
